vga_pixel_output: RTL and testbench

- Downstream stage of the VGA application colour multiplexer.
- Generates 640x480@60 VGA timing and exposes the current pixel coordinates so the colour functions can compute their pixels.
- Samples the multiplexer's DATA_WIDTH-bit colour word, gates it with blanking, and drives registered R/G/B, sync and blank signals to the DAC/connector.
- Counters advance on a pixel-rate enable tick.

---
 rtl/vga_pixel_output.sv | 106 ++++++++++
 tb/tb_vga_pixel_output.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_output.sv
// 640x480@60 VGA timing generator and output stage: counts pixels on the pixel tick,
// exposes (x, y) to the colour logic and drives blank-gated RGB with sync/blank one tick later.
module vga_pixel_output #(
  parameter int DATA_WIDTH = 24,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CNT_WIDTH  = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pixel_en,
  input  logic [DATA_WIDTH-1:0]   color_in,
  output logic [CNT_WIDTH-1:0]    x,
  output logic [CNT_WIDTH-1:0]    y,
  output logic                    active,
  output logic                    frame_start,
  output logic [DATA_WIDTH/3-1:0] red,
  output logic [DATA_WIDTH/3-1:0] green,
  output logic [DATA_WIDTH/3-1:0] blue,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    blank_n,
  output logic                    sync_n
);

  localparam int CW      = DATA_WIDTH / 3;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_WIDTH-1:0] H_ACT_C = CNT_WIDTH'(H_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] H_SS_C  = CNT_WIDTH'(H_ACTIVE + H_FP);
  localparam logic [CNT_WIDTH-1:0] H_SE_C  = CNT_WIDTH'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_WIDTH-1:0] H_LAST  = CNT_WIDTH'(H_TOTAL - 1);
  localparam logic [CNT_WIDTH-1:0] V_ACT_C = CNT_WIDTH'(V_ACTIVE);
  localparam logic [CNT_WIDTH-1:0] V_SS_C  = CNT_WIDTH'(V_ACTIVE + V_FP);
  localparam logic [CNT_WIDTH-1:0] V_SE_C  = CNT_WIDTH'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_WIDTH-1:0] V_LAST  = CNT_WIDTH'(V_TOTAL - 1);

  logic [CNT_WIDTH-1:0]  h_cnt_p0, v_cnt_p0;
  logic                  hs_i, vs_i;
  logic [3*CW-1:0]       rgb_p1;
  logic                  hs_p1, vs_p1, blank_p1, fs_p1;

  // Colour is only passed through inside the visible region.
  function automatic logic [3*CW-1:0] blank_gate(input logic [DATA_WIDTH-1:0] c,
                                                 input logic vis);
    return vis ? c[3*CW-1:0] : '0;
  endfunction

  // Stage p0: counter decode
  always_comb begin
    active = (h_cnt_p0 < H_ACT_C) && (v_cnt_p0 < V_ACT_C);
    hs_i   = !((h_cnt_p0 >= H_SS_C) && (h_cnt_p0 < H_SE_C));
    vs_i   = !((v_cnt_p0 >= V_SS_C) && (v_cnt_p0 < V_SE_C));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_p0 <= '0;
      v_cnt_p0 <= '0;
      rgb_p1   <= '0;
      hs_p1    <= 1'b1;
      vs_p1    <= 1'b1;
      blank_p1 <= 1'b0;
      fs_p1    <= 1'b0;
    end else begin
      fs_p1 <= 1'b0;
      if (pixel_en) begin
        if (h_cnt_p0 == H_LAST) begin
          h_cnt_p0 <= '0;
          if (v_cnt_p0 == V_LAST) begin
            v_cnt_p0 <= '0;
            fs_p1    <= 1'b1;
          end else begin
            v_cnt_p0 <= v_cnt_p0 + 1'b1;
          end
        end else begin
          h_cnt_p0 <= h_cnt_p0 + 1'b1;
        end
        // Stage p1: outputs lag the counters by exactly one pixel tick
        rgb_p1   <= blank_gate(color_in, active);
        hs_p1    <= hs_i;
        vs_p1    <= vs_i;
        blank_p1 <= active;
      end
    end
  end

  assign x           = h_cnt_p0;
  assign y           = v_cnt_p0;
  assign frame_start = fs_p1;
  assign red         = rgb_p1[3*CW-1:2*CW];
  assign green       = rgb_p1[2*CW-1:CW];
  assign blue        = rgb_p1[CW-1:0];
  assign hsync       = hs_p1;
  assign vsync       = vs_p1;
  assign blank_n     = blank_p1;
  assign sync_n      = 1'b0;

endmodule

// File: tb/tb_vga_pixel_output.sv
// Directed bench for vga_pixel_output: full-size instance for line/colour/stall checks,
// shrunken-timing instance for frame-level vsync and frame_start checks.
module tb_vga_pixel_output;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pixel_en = 1'b0;
  logic [23:0] color_in = '0;

  logic [9:0] x, y;
  logic       active, frame_start, hsync, vsync, blank_n, sync_n;
  logic [7:0] red, green, blue;

  logic [9:0] sx, sy;
  logic       sactive, sfs, shs, svs, sbl, ssn;
  logic [7:0] sr, sg, sb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  vga_pixel_output u_dut (
    .clk(clk), .rst(rst), .pixel_en(pixel_en), .color_in(color_in),
    .x(x), .y(y), .active(active), .frame_start(frame_start),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .sync_n(sync_n)
  );

  // H_TOTAL = 8+2+3+2 = 15, V_TOTAL = 4+1+2+1 = 8, frame = 120 ticks
  vga_pixel_output #(
    .DATA_WIDTH(24), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .CNT_WIDTH(10)
  ) u_small (
    .clk(clk), .rst(rst), .pixel_en(pixel_en), .color_in(color_in),
    .x(sx), .y(sy), .active(sactive), .frame_start(sfs),
    .red(sr), .green(sg), .blue(sb),
    .hsync(shs), .vsync(svs), .blank_n(sbl), .sync_n(ssn)
  );

  task automatic tick(input logic en);
    pixel_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(1'b1); tick(1'b0); tick(1'b1);
    n_cmp++; if (x !== 10'd0)              begin n_err++; $display("FAIL reset_x got %0d want 0", x); end
    n_cmp++; if (y !== 10'd0)              begin n_err++; $display("FAIL reset_y got %0d want 0", y); end
    n_cmp++; if ({red,green,blue} !== 24'h0) begin n_err++; $display("FAIL reset_rgb got %h want 000000", {red,green,blue}); end
    n_cmp++; if (hsync !== 1'b1)           begin n_err++; $display("FAIL reset_hsync got %b want 1", hsync); end
    n_cmp++; if (vsync !== 1'b1)           begin n_err++; $display("FAIL reset_vsync got %b want 1", vsync); end
    n_cmp++; if (blank_n !== 1'b0)         begin n_err++; $display("FAIL reset_blank_n got %b want 0", blank_n); end
    n_cmp++; if (frame_start !== 1'b0)     begin n_err++; $display("FAIL reset_frame_start got %b want 0", frame_start); end
    n_cmp++; if (sync_n !== 1'b0)          begin n_err++; $display("FAIL sync_n got %b want 0", sync_n); end
    n_cmp++; if (active !== 1'b1)          begin n_err++; $display("FAIL reset_active got %b want 1", active); end
    rst = 1'b0;
  endtask

  task automatic test_line;
    int hs_low = 0, bl_hi = 0, first_low = -1, fs_cnt = 0;
    color_in = 24'hFF8001;
    for (int k = 1; k <= 800; k++) begin
      tick(1'b1);
      if (!hsync) begin
        if (hs_low == 0) first_low = k - 1;
        hs_low++;
      end
      if (blank_n) bl_hi++;
      if (frame_start) fs_cnt++;
      if (k == 1) begin
        n_cmp++; if ({red,green,blue} !== 24'hFF8001) begin n_err++; $display("FAIL rgb_x0 got %h want ff8001", {red,green,blue}); end
      end
      if (k == 640) begin
        n_cmp++; if ({red,green,blue} !== 24'hFF8001) begin n_err++; $display("FAIL rgb_x639 got %h want ff8001", {red,green,blue}); end
      end
      if (k == 641) begin
        n_cmp++; if ({red,green,blue} !== 24'h0) begin n_err++; $display("FAIL rgb_x640 got %h want 000000", {red,green,blue}); end
        n_cmp++; if (blank_n !== 1'b0) begin n_err++; $display("FAIL blank_x640 got %b want 0", blank_n); end
      end
      if (k == 799) begin
        n_cmp++; if (x !== 10'd799 || y !== 10'd0) begin n_err++; $display("FAIL pos_799 got (%0d,%0d) want (799,0)", x, y); end
      end
    end
    n_cmp++; if (hs_low !== 96)    begin n_err++; $display("FAIL hsync_width got %0d want 96", hs_low); end
    n_cmp++; if (first_low !== 656) begin n_err++; $display("FAIL hsync_start got %0d want 656", first_low); end
    n_cmp++; if (bl_hi !== 640)    begin n_err++; $display("FAIL blank_width got %0d want 640", bl_hi); end
    n_cmp++; if (x !== 10'd0 || y !== 10'd1) begin n_err++; $display("FAIL line_wrap got (%0d,%0d) want (0,1)", x, y); end
    n_cmp++; if (fs_cnt !== 0)     begin n_err++; $display("FAIL line_frame_start got %0d want 0", fs_cnt); end
  endtask

  task automatic test_colour;
    color_in = 24'h123456;
    tick(1'b1);
    n_cmp++; if ({red,green,blue} !== 24'h123456) begin n_err++; $display("FAIL colour_a got %h want 123456", {red,green,blue}); end
    color_in = 24'hABCDEF;
    tick(1'b1);
    n_cmp++; if (red !== 8'hAB || green !== 8'hCD || blue !== 8'hEF)
      begin n_err++; $display("FAIL colour_b got %h/%h/%h want ab/cd/ef", red, green, blue); end
  endtask

  task automatic test_stall;
    logic [9:0] exp_x [6] = '{10'd3, 10'd3, 10'd4, 10'd4, 10'd5, 10'd5};
    logic [23:0] held;
    int bad = 0;
    for (int k = 0; k < 6; k++) begin
      color_in = (k % 2 == 0) ? 24'h00FF00 + 24'(k) : 24'h0000AA;
      tick((k % 2) == 0);
      if (x !== exp_x[k]) bad++;
      if (k % 2 == 0) held = {red,green,blue};
      else if ({red,green,blue} !== held) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL stall_seq got %0d bad samples want 0", bad); end
    n_cmp++; if ({red,green,blue} !== 24'h00FF04) begin n_err++; $display("FAIL stall_rgb got %h want 00ff04", {red,green,blue}); end
    color_in = 24'h777777;
    for (int k = 0; k < 5; k++) tick(1'b0);
    n_cmp++; if (x !== 10'd5 || {red,green,blue} !== 24'h00FF04 || hsync !== 1'b1 || blank_n !== 1'b1)
      begin n_err++; $display("FAIL frozen got x=%0d rgb=%h hs=%b bl=%b want 5/00ff04/1/1", x, {red,green,blue}, hsync, blank_n); end
  endtask

  task automatic test_mid_reset;
    color_in = 24'h102030;
    for (int k = 0; k < 295; k++) tick(1'b1);
    n_cmp++; if (x !== 10'd300 || y !== 10'd1) begin n_err++; $display("FAIL pre_reset_pos got (%0d,%0d) want (300,1)", x, y); end
    rst = 1'b1;
    tick(1'b1);
    rst = 1'b0;
    n_cmp++; if (x !== 10'd0 || y !== 10'd0 || hsync !== 1'b1 || vsync !== 1'b1 || {red,green,blue} !== 24'h0)
      begin n_err++; $display("FAIL mid_reset got (%0d,%0d) hs=%b vs=%b rgb=%h want (0,0) 1 1 000000", x, y, hsync, vsync, {red,green,blue}); end
    tick(1'b1);
    n_cmp++; if (x !== 10'd1 || {red,green,blue} !== 24'h102030)
      begin n_err++; $display("FAIL resume got x=%0d rgb=%h want 1/102030", x, {red,green,blue}); end
  endtask

  task automatic test_frame;
    int vs_low = 0, vs_first = -1, bl_hi = 0, fs1 = -1, fs2 = -1, fs_cnt = 0;
    rst = 1'b1; tick(1'b1); rst = 1'b0;
    color_in = 24'h0F0F0F;
    for (int k = 1; k <= 240; k++) begin
      tick(1'b1);
      if (k <= 120) begin
        if (!svs) begin
          if (vs_low == 0) vs_first = k;
          vs_low++;
        end
        if (sbl) bl_hi++;
      end
      if (sfs) begin
        fs_cnt++;
        if (fs1 < 0) fs1 = k; else fs2 = k;
      end
    end
    n_cmp++; if (vs_low !== 30)   begin n_err++; $display("FAIL vsync_width got %0d want 30", vs_low); end
    n_cmp++; if (vs_first !== 76) begin n_err++; $display("FAIL vsync_start got %0d want 76", vs_first); end
    n_cmp++; if (bl_hi !== 32)    begin n_err++; $display("FAIL frame_blank got %0d want 32", bl_hi); end
    n_cmp++; if (fs_cnt !== 2 || fs1 !== 120 || fs2 !== 240)
      begin n_err++; $display("FAIL frame_start got n=%0d at %0d,%0d want 2 at 120,240", fs_cnt, fs1, fs2); end
    n_cmp++; if (sx !== 10'd0 || sy !== 10'd0) begin n_err++; $display("FAIL frame_wrap got (%0d,%0d) want (0,0)", sx, sy); end
    tick(1'b0);
    n_cmp++; if (sfs !== 1'b0) begin n_err++; $display("FAIL fs_one_clk got %b want 0", sfs); end
  endtask

  task automatic test_small_mid_reset;
    int fs_at = -1;
    for (int k = 0; k < 52; k++) tick(1'b1);
    n_cmp++; if (sx !== 10'd7 || sy !== 10'd3) begin n_err++; $display("FAIL small_pos got (%0d,%0d) want (7,3)", sx, sy); end
    rst = 1'b1; tick(1'b1); rst = 1'b0;
    for (int k = 1; k <= 125; k++) begin
      tick(1'b1);
      if (sfs && fs_at < 0) fs_at = k;
    end
    n_cmp++; if (fs_at !== 120) begin n_err++; $display("FAIL fs_after_reset got %0d want 120", fs_at); end
  endtask

  initial begin
    test_reset;
    test_line;
    test_colour;
    test_stall;
    test_mid_reset;
    test_frame;
    test_small_mid_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
